// File: rtl/seg_pkg.sv
// Shared constants and types for the six-digit multiplexed seven-segment scanner.
package seg_pkg;

  localparam int unsigned SEG_DIGITS = 6;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [5:0]  SEL_OFF    = 6'h3F;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_t;

  // Active-low g..a patterns for hex 0-F (bit 0 = segment a).
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_CODE[i_hex];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment scan controller with double-buffered frame loading.
// Optional leading-zero suppression is compiled in with SEG_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [23:0] load_data,
  input  logic [5:0]  load_dp,
  output logic        frame_done,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int unsigned CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(SEG_DIGITS - 1);

  scan_state_t r_state, w_state_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]    r_sel, w_sel_nxt;
  logic [7:0]    r_seg, w_seg_nxt;
  logic          r_frame_done;
  logic          w_boundary;
  logic          w_accept;
  logic [23:0]   r_disp_data, r_pend_data;
  logic [5:0]    r_disp_dp, r_pend_dp;
  logic          r_pend_full;
  logic [3:0]    w_nib;
  logic [6:0]    w_code;
  logic          w_zblank;

  // Outputs are precomputed from the next state so they switch on the transition edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_BLANK;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_sel        <= SEL_OFF;
      r_seg        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_boundary;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_boundary  = 1'b0;
    unique case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_boundary  = (r_idx == IDX_LAST);
          w_idx_nxt   = w_boundary ? '0 : r_idx + 1'b1;
        end
      end
    endcase
  end

  assign w_nib = r_disp_data[{w_idx_nxt, 2'b00} +: 4];

  seg_decode u_decode (
    .i_hex (w_nib),
    .o_seg (w_code)
  );

`ifdef SEG_ZERO_BLANK_EN
  always_comb begin
    w_zblank = (w_idx_nxt != '0);
    for (int unsigned j = 0; j < SEG_DIGITS; j++) begin
      if (j >= 32'(w_idx_nxt) && (r_disp_data[4*j +: 4] != 4'h0 || r_disp_dp[j]))
        w_zblank = 1'b0;
    end
  end
`else
  assign w_zblank = 1'b0;
`endif

  always_comb begin
    w_sel_nxt = SEL_OFF;
    w_seg_nxt = SEG_OFF;
    if (w_state_nxt == ST_DRIVE) begin
      w_sel_nxt = ~(6'd1 << w_idx_nxt);
      w_seg_nxt = w_zblank ? SEG_OFF : {~r_disp_dp[w_idx_nxt], w_code};
    end
  end

  assign w_accept = load_valid && !r_pend_full;

  // Accept requires an empty buffer, so it never collides with a boundary copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_boundary && r_pend_full) begin
      r_disp_data <= r_pend_data;
      r_disp_dp   <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_data <= load_data;
      r_pend_dp   <= load_dp;
      r_pend_full <= 1'b1;
    end
  end

  assign load_ready = ~r_pend_full;
  assign frame_done = r_frame_done;
  assign sel        = en ? r_sel : SEL_OFF;
  assign seg        = en ? r_seg : SEG_OFF;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference model predicts every cycle.
module tb_seg_scan_ctrl;

  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 6 * SLOT;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b1;
  logic        load_valid = 1'b0;
  logic [23:0] load_data = '0;
  logic [5:0]  load_dp = '0;
  logic        load_ready, frame_done;
  logic [5:0]  sel;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .frame_done (frame_done),
    .sel        (sel),
    .seg        (seg)
  );

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: absolute cycle count since reset release decides the scan position.
  int          m_t = 0;
  logic [23:0] m_disp = '0, m_pend = '0;
  logic [5:0]  m_disp_dp = '0, m_pend_dp = '0;
  bit          m_full = 1'b0;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [7:0] glyph(input int d);
    logic [3:0] nib;
    bit         blank;
    nib   = 4'(m_disp >> (4 * d));
    blank = 1'b0;
`ifdef SEG_ZERO_BLANK_EN
    blank = (d > 0) && ((m_disp >> (4 * d)) == 24'd0) && ((m_disp_dp >> d) == 6'd0);
`endif
    return blank ? 8'hFF : {~m_disp_dp[d], FONT[nib]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   p;
    bit   acc;
    if (!rstn) begin
      m_t    = 0;
      m_disp = '0; m_disp_dp = '0;
      m_pend = '0; m_pend_dp = '0;
      m_full = 1'b0;
    end else begin
      acc = load_valid && !m_full;
      m_t++;
      if ((m_t % FRAME) == 0 && m_full) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_full = 1'b0;
      end else if (acc) begin
        m_pend = load_data; m_pend_dp = load_dp; m_full = 1'b1;
      end
    end
    p     = m_t % FRAME;
    e.fd  = (m_t > 0) && (p == 0);
    e.rdy = !m_full;
    if (en && rstn && (p % SLOT) >= BL) begin
      e.sel = ~(6'd1 << (p / SLOT));
      e.seg = glyph(p / SLOT);
    end else begin
      e.sel = 6'h3F;
      e.seg = 8'hFF;
    end
    q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sel", 32'(sel), 32'(e.sel));
      chk("seg", 32'(seg), 32'(e.seg));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      chk("load_ready", 32'(load_ready), 32'(e.rdy));
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    @(negedge clk);
    while ((m_t % FRAME) != p && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos_timeout", 32'((m_t % FRAME) == p), 32'd1);
  endtask

  task automatic send(input logic [23:0] d, input logic [5:0] dp);
    int n = 0;
    load_data  = d;
    load_dp    = dp;
    load_valid = 1'b1;
    while (!load_ready && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(load_ready), 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn       = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 32'h3F);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    repeat (n) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2;
    rstn = 1'b0;
    #1;
    chk("init_sel", 32'(sel), 32'h3F);
    chk("init_seg", 32'(seg), 32'hFF);
    chk("init_ready", 32'(load_ready), 32'd1);
    chk("init_fd", 32'(frame_done), 32'd0);
    ticks(3);
    rstn = 1'b1;

    ticks(FRAME + 5);

    wait_pos(25);
    send(24'h123456, 6'b000100);
    ticks(2 * FRAME);

    wait_pos(15);
    send(24'hAAAAAA, 6'b000000);
    send(24'h555555, 6'b000000);
    ticks(3 * FRAME);

    wait_pos(15);
    en = 1'b0;
    ticks(20);
    en = 1'b1;
    ticks(FRAME);

    send(24'h000042, 6'b000000);
    ticks(2 * FRAME);
    send(24'h000000, 6'b000000);
    ticks(2 * FRAME);

    send(24'hABCDEF, 6'b111111);
    ticks(2 * FRAME);
    wait_pos(5);
    send(24'h987654, 6'b010101);
    wait_pos(33);
    do_reset(3);
    ticks(FRAME + 5);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 24'($urandom);
      load_dp    = 6'($urandom);
      en         = ($urandom_range(0, 15) != 0);
    end
    @(negedge clk);
    load_valid = 1'b0;
    en         = 1'b1;
    ticks(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 50000, clock cycles each digit is driven (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 500, all-off guard cycles before each digit (anti-ghosting); legal range 1..DWELL_CYC.
REQ-003 SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  display enable; 0 forces all outputs off.
REQ-006 SHALL have port load_valid  input  1  new frame data offered.
REQ-007 SHALL have port load_ready  output  1  pending buffer free.
REQ-008 SHALL have port load_data  input  24  six hex nibbles; nibble i = digit i, digit 0 rightmost.
REQ-009 SHALL have port load_dp  input  6  decimal point per digit, 1 = lit.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-011 SHALL have port sel  output  6  digit select, one-hot active-low, sel[i] = digit i.
REQ-012 SHALL have port seg  output  8  segments active-low, seg[7] = dp, seg[6:0] = g..a.

Function
REQ-013 SHALL run FSM with states BLANK and DRIVE plus a 3-bit digit index 0..5 and one dwell counter sized for max(DWELL_CYC, BLANK_CYC).
REQ-014 SHALL stay in BLANK exactly BLANK_CYC cycles, then DRIVE exactly DWELL_CYC cycles, then BLANK for index+1; index 5 wraps to 0.
REQ-015 SHALL register sel/seg so they change on the same edge as the state transition; BLANK drives sel=6'h3F, seg=8'hFF.
REQ-016 SHALL in DRIVE assert only sel[index] low and drive seg = decode(display nibble[index]) with seg[7] = ~display_dp[index].
REQ-017 SHALL decode all 16 hex values (0-9, A-F) in the decode sub-module.
REQ-018 SHALL accept load when load_valid && load_ready, storing data/dp in the pending buffer and setting pending-full.
REQ-019 SHALL drive load_ready = ~pending_full; load_valid while load_ready=0 has no effect.
REQ-020 SHALL define frame boundary as the DRIVE->BLANK transition out of index 5; there copy pending to display registers if pending_full, clear pending_full, pulse frame_done.
REQ-021 SHALL, when accept and boundary coincide with pending empty, apply the new data at the next boundary (not the current one).
REQ-022 SHALL never change displayed data mid-frame (no tearing).
REQ-023 SHALL, when en=0, keep FSM/counters running and force sel=6'h3F, seg=8'hFF; on en rising, resume at current state with no restart.

Reset
REQ-024 SHALL on rstn=0 immediately set state=BLANK, index=0, counter=0, sel=6'h3F, seg=8'hFF, load_ready=1, frame_done=0, display data=0, display dp=0, pending_full=0.
REQ-025 SHALL discard any pending load and partially scanned frame on reset mid-operation; first DRIVE after release is index 0 after BLANK_CYC cycles.

Configuration
REQ-026 SHALL compile leading-zero suppression only when SEG_ZERO_BLANK_EN is defined: digit i (i>=1) is blanked (seg=8'hFF, sel still asserted) if nibbles i..5 are all 0 and dp i..5 all 0; digit 0 never blanked.
REQ-027 SHALL without SEG_ZERO_BLANK_EN display every digit including leading zeros.

Structure
REQ-028 SHALL place digit count (6), segment code table constants, SEG_OFF (8'hFF) and SEL_OFF (6'h3F) in shared package seg_pkg.
REQ-029 SHALL implement hex-to-segment decode as sub-module seg_decode (combinational, 4-bit in, 7-bit out).

Verification (DWELL_CYC=8, BLANK_CYC=2, frame = 60 cycles)
REQ-030 SHALL cover: release reset, no load -> sel walks 3E,3D,3B,37,2F,1F each 8 cycles with 2 cycles 3F between; seg=8'hC0 ("0") during DRIVE.
REQ-031 SHALL cover: load 24'h123456, dp=6'b000100 mid-frame -> load_ready falls next cycle; old data until boundary; next frame digit0 seg=8'h82 ("6"), digit2 seg=8'h19 ("4" with dp); frame_done one pulse per 60 cycles.
REQ-032 SHALL cover: two back-to-back loads (AAAAAA then 555555) in one frame -> second held off by load_ready=0, accepted after boundary, displayed one frame later.
REQ-033 SHALL cover: en=0 for 20 cycles mid-DRIVE -> sel=3F, seg=FF throughout; frame_done period unchanged.
REQ-034 SHALL cover: with SEG_ZERO_BLANK_EN, load 24'h000042 dp=0 -> digits 5..2 seg=FF, digit1 "4", digit0 "2"; load 24'h000000 -> only digit 0 shows "0".
REQ-035 SHALL cover: rstn low for 3 cycles during digit 3 with pending_full=1 -> outputs off immediately, load_ready=1, display shows zeros after release.
